// File: rtl/stream_burst_tx_if.sv
// Valid/ready bundle between a burst transmitter and its command source / stream sink.
// master = the transmitter side, slave = the environment (command issuer and downstream sink).
interface stream_burst_tx_if #(
  parameter int DataWidth = 16,
  parameter int LenWidth  = 8
);
  logic [DataWidth-1:0] cmd_start_i;
  logic [LenWidth-1:0]  cmd_len_i;
  logic                 cmd_val_i;
  logic                 cmd_rdy_o;
  logic [DataWidth-1:0] dout_o;
  logic                 dout_val_o;
  logic                 dout_rdy_i;
  logic                 dout_last_o;

  modport master (
    input  cmd_start_i, cmd_len_i, cmd_val_i, dout_rdy_i,
    output cmd_rdy_o, dout_o, dout_val_o, dout_last_o
  );

  modport slave (
    output cmd_start_i, cmd_len_i, cmd_val_i, dout_rdy_i,
    input  cmd_rdy_o, dout_o, dout_val_o, dout_last_o
  );
endinterface

// File: rtl/stream_burst_tx.sv
// Command-driven burst transmitter: one (start, len) command becomes len beats on a valid/ready stream.
// Define STREAM_BURST_TX_LFSR_EN to step beats with a Galois LFSR instead of incrementing.
module stream_burst_tx #(
  parameter int                   DataWidth = 16,
  parameter int                   LenWidth  = 8,
  parameter logic [DataWidth-1:0] LfsrTaps  = 16'hB400
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  stream_burst_tx_if.master        bus,
  output logic                     busy_o,
  output logic                     done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [DataWidth-1:0] r_value;
  logic [LenWidth-1:0]  r_remaining;
  logic [DataWidth-1:0] w_seed;
  logic [DataWidth-1:0] w_value_next;
  logic                 w_cmd_hs;
  logic                 w_beat_hs;
  logic                 w_last;

`ifdef STREAM_BURST_TX_LFSR_EN
  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  assign w_seed       = (bus.cmd_start_i == '0) ? DataWidth'(1) : bus.cmd_start_i;
  assign w_value_next = (r_value >> 1) ^ (r_value[0] ? LfsrTaps : '0);
`else
  logic w_unused_taps;
  assign w_unused_taps = ^LfsrTaps;
  assign w_seed        = bus.cmd_start_i;
  assign w_value_next  = r_value + DataWidth'(1);
`endif

  assign bus.cmd_rdy_o = (r_state == IDLE) && !rst_i;
  assign w_cmd_hs      = bus.cmd_val_i && bus.cmd_rdy_o;
  assign w_beat_hs     = (r_state == SEND) && bus.dout_rdy_i;
  assign w_last        = (r_remaining == LenWidth'(1));

  // Outputs decode only from registered state, never from the incoming valid/ready.
  assign bus.dout_val_o  = (r_state == SEND);
  assign bus.dout_o      = (r_state == SEND) ? r_value : '0;
  assign bus.dout_last_o = (r_state == SEND) && w_last;
  assign busy_o          = (r_state != IDLE);
  assign done_o          = (r_state == DONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_cmd_hs) begin
          w_next_state = (bus.cmd_len_i != '0) ? SEND : DONE;
        end
      end
      SEND: begin
        if (w_beat_hs && w_last) begin
          w_next_state = DONE;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_value     <= '0;
      r_remaining <= '0;
    end else if (w_cmd_hs) begin
      r_value     <= w_seed;
      r_remaining <= bus.cmd_len_i;
    end else if (w_beat_hs) begin
      r_value     <= w_value_next;
      r_remaining <= r_remaining - LenWidth'(1);
    end
  end

endmodule

// File: tb/tb_stream_burst_tx.sv
// Directed self-checking bench for stream_burst_tx; expectations are hand-computed beat tables.
// Build with STREAM_BURST_TX_LFSR_EN to run the LFSR expectations instead of the incrementing ones.
module tb_stream_burst_tx;

  logic clk_i;
  logic rst_i;
  logic busy_o;
  logic done_o;

  int compared;
  int mismatched;

  logic [15:0] expBeats [0:9];

  stream_burst_tx_if #(.DataWidth(16), .LenWidth(8)) bus ();

  stream_burst_tx #(
    .DataWidth(16),
    .LenWidth (8),
    .LfsrTaps (16'hB400)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus),
    .busy_o(busy_o),
    .done_o(done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Presents one command while idle and retires it on the next edge.
  task automatic applyStimulus(input logic [15:0] start, input logic [7:0] len);
    checkOutput("cmd_rdy_idle", {31'd0, bus.cmd_rdy_o}, 32'd1);
    bus.cmd_start_i = start;
    bus.cmd_len_i   = len;
    bus.cmd_val_i   = 1'b1;
    step();
    bus.cmd_val_i   = 1'b0;
    checkOutput("busy_after_accept", {31'd0, busy_o}, 32'd1);
    checkOutput("cmd_rdy_after_accept", {31'd0, bus.cmd_rdy_o}, 32'd0);
  endtask

  // Walks a burst against expBeats, optionally stalling 1,0,0,1 and poking stray commands.
  task automatic drainBurst(input int n, input bit stall, input bit pokeCmd);
    int hs  = 0;
    int cyc = 0;
    while (hs < n && cyc < 64) begin
      checkOutput("beat_valid", {31'd0, bus.dout_val_o}, 32'd1);
      checkOutput("beat_data", {16'd0, bus.dout_o}, {16'd0, expBeats[hs]});
      checkOutput("beat_last", {31'd0, bus.dout_last_o}, (hs == n - 1) ? 32'd1 : 32'd0);
      checkOutput("done_during_send", {31'd0, done_o}, 32'd0);
      bus.dout_rdy_i = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (pokeCmd) begin
        bus.cmd_start_i = 16'hDEAD;
        bus.cmd_len_i   = 8'd5;
        bus.cmd_val_i   = 1'b1;
      end
      if (bus.dout_rdy_i) hs++;
      cyc++;
      step();
    end
    checkOutput("burst_handshakes", hs, n);
    bus.cmd_val_i  = 1'b0;
    bus.dout_rdy_i = 1'b1;
    checkOutput("done_pulse", {31'd0, done_o}, 32'd1);
    checkOutput("done_no_valid", {31'd0, bus.dout_val_o}, 32'd0);
    checkOutput("done_busy", {31'd0, busy_o}, 32'd1);
    step();
    checkOutput("done_one_cycle", {31'd0, done_o}, 32'd0);
    checkOutput("idle_cmd_rdy", {31'd0, bus.cmd_rdy_o}, 32'd1);
    checkOutput("idle_not_busy", {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    compared        = 0;
    mismatched      = 0;
    rst_i           = 1'b1;
    bus.cmd_start_i = '0;
    bus.cmd_len_i   = '0;
    bus.cmd_val_i   = 1'b0;
    bus.dout_rdy_i  = 1'b1;
    for (int i = 0; i < 10; i++) expBeats[i] = '0;

    step();
    step();
    checkOutput("rst_cmd_rdy", {31'd0, bus.cmd_rdy_o}, 32'd0);
    checkOutput("rst_valid", {31'd0, bus.dout_val_o}, 32'd0);
    checkOutput("rst_data", {16'd0, bus.dout_o}, 32'd0);
    checkOutput("rst_last", {31'd0, bus.dout_last_o}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("rst_done", {31'd0, done_o}, 32'd0);

    rst_i = 1'b0;
    step();
    step();
    checkOutput("idle_cmd_rdy", {31'd0, bus.cmd_rdy_o}, 32'd1);
    checkOutput("idle_no_beat", {31'd0, bus.dout_val_o}, 32'd0);

`ifdef STREAM_BURST_TX_LFSR_EN
    expBeats[0] = 16'h0001; expBeats[1] = 16'hB400; expBeats[2] = 16'h5A00;
    applyStimulus(16'h0001, 8'd3);
    drainBurst(3, 1'b0, 1'b0);

    expBeats[0] = 16'h0001; expBeats[1] = 16'hB400;
    applyStimulus(16'h0000, 8'd2);
    drainBurst(2, 1'b0, 1'b0);
`else
    // Straight burst with stray commands offered while busy.
    expBeats[0] = 16'h0010; expBeats[1] = 16'h0011; expBeats[2] = 16'h0012; expBeats[3] = 16'h0013;
    applyStimulus(16'h0010, 8'd4);
    drainBurst(4, 1'b0, 1'b1);
    step();
    checkOutput("stray_cmd_not_queued", {31'd0, bus.dout_val_o}, 32'd0);

    applyStimulus(16'h0010, 8'd4);
    drainBurst(4, 1'b1, 1'b0);

    expBeats[0] = 16'hFFFE; expBeats[1] = 16'hFFFF; expBeats[2] = 16'h0000;
    applyStimulus(16'hFFFE, 8'd3);
    drainBurst(3, 1'b0, 1'b0);

    // Zero-length: straight to DONE with no beat.
    bus.cmd_start_i = 16'h1234;
    bus.cmd_len_i   = 8'd0;
    bus.cmd_val_i   = 1'b1;
    step();
    bus.cmd_val_i   = 1'b0;
    checkOutput("zero_len_done", {31'd0, done_o}, 32'd1);
    checkOutput("zero_len_no_beat", {31'd0, bus.dout_val_o}, 32'd0);
    step();
    checkOutput("zero_len_done_clear", {31'd0, done_o}, 32'd0);
    checkOutput("zero_len_cmd_rdy", {31'd0, bus.cmd_rdy_o}, 32'd1);
    checkOutput("zero_len_still_no_beat", {31'd0, bus.dout_val_o}, 32'd0);

    // Reset after three handshakes aborts the burst without a done pulse.
    applyStimulus(16'h0100, 8'd10);
    step();
    step();
    step();
    checkOutput("midburst_data", {16'd0, bus.dout_o}, 32'h0103);
    rst_i = 1'b1;
    step();
    checkOutput("abort_valid", {31'd0, bus.dout_val_o}, 32'd0);
    checkOutput("abort_done", {31'd0, done_o}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("abort_cmd_rdy_in_rst", {31'd0, bus.cmd_rdy_o}, 32'd0);
    rst_i = 1'b0;
    #1;
    checkOutput("abort_cmd_rdy", {31'd0, bus.cmd_rdy_o}, 32'd1);
    step();
    checkOutput("abort_no_done_later", {31'd0, done_o}, 32'd0);
    checkOutput("abort_no_beat_later", {31'd0, bus.dout_val_o}, 32'd0);

    expBeats[0] = 16'h0200; expBeats[1] = 16'h0201;
    applyStimulus(16'h0200, 8'd2);
    drainBurst(2, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
